// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority queue among NREQ requesters.
// Serialises enqueue/dequeue requests and returns a one-hot ack per operation.
module pq_arbiter #(
  parameter int NREQ = 4,
  parameter int KW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           op,
  input  logic [NREQ*KW-1:0]        key_in,
  output logic [NREQ-1:0]           ack,
  output logic                      nack,
  output logic [KW-1:0]             rdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      pq_enq,
  output logic                      pq_deq,
  output logic [KW-1:0]             pq_kin,
  input  logic [KW-1:0]             pq_kout,
  input  logic                      pq_busy,
  input  logic                      pq_full,
  input  logic                      pq_empty,
  output logic [7:0]                rej_cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            win_vld;
  logic            op_q;
  logic [KW-1:0]   key_q;
  logic            rej_q;
  logic            reject;

  // Rotating search: the first requester at or after ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign reject = op_q ? pq_empty : pq_full;

  always_comb begin
    state_nx = state;
    pq_enq   = 1'b0;
    pq_deq   = 1'b0;
    pq_kin   = '0;
    ack      = '0;
    nack     = 1'b0;
    case (state)
      IDLE:  if (win_vld) state_nx = ISSUE;
      ISSUE: begin
        if (reject) begin
          state_nx = RESP;
        end else if (!pq_busy) begin
          pq_enq   = !op_q;
          pq_deq   = op_q;
          pq_kin   = op_q ? '0 : key_q;
          state_nx = WAIT;
        end
      end
      WAIT:  if (!pq_busy) state_nx = RESP;
      RESP: begin
        ack[gnt_id] = 1'b1;
        nack        = rej_q;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      gnt_id  <= '0;
      op_q    <= 1'b0;
      key_q   <= '0;
      rej_q   <= 1'b0;
      rej_cnt <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          gnt_id <= win;
          op_q   <= op[win];
          key_q  <= key_in[32'(win)*KW +: KW];
          ptr    <= (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
        ISSUE: begin
          if (reject) begin
            rej_q <= 1'b1;
            if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
          end else if (!pq_busy && op_q) begin
            rdata <= pq_kout;
          end
        end
        RESP: rej_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// Bench for pq_arbiter: directed vector table, hand sequences and a randomized
// run against a transaction-level model with a bench-owned priority queue.
module tb_pq_arbiter;
  localparam int NREQ = 4;
  localparam int KW   = 16;
  localparam int CAP  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, op, ack;
  logic [NREQ*KW-1:0] key_in;
  logic              nack, pq_enq, pq_deq, pq_busy, pq_full, pq_empty;
  logic [KW-1:0]     rdata, pq_kin, pq_kout;
  logic [1:0]        gnt_id;
  logic [7:0]        rej_cnt;

  pq_arbiter #(.NREQ(NREQ), .KW(KW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .key_in(key_in), .ack(ack),
    .nack(nack), .rdata(rdata), .gnt_id(gnt_id), .pq_enq(pq_enq),
    .pq_deq(pq_deq), .pq_kin(pq_kin), .pq_kout(pq_kout), .pq_busy(pq_busy),
    .pq_full(pq_full), .pq_empty(pq_empty), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic        force_full;
  logic [15:0] q[$];
  logic [15:0] last_rd;

  typedef struct {
    int          id;
    logic        op;
    logic [15:0] key;
    int          bpre;
    int          bpost;
    logic        full;
    logic        rej;
    int          lat;
    logic [15:0] rd;
    logic [7:0]  rc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] qmin();
    logic [15:0] m;
    m = 16'hFFFF;
    if (q.size() == 0) return 16'h0;
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic void qremove_min();
    int idx;
    logic [15:0] m;
    if (q.size() == 0) return;
    idx = 0;
    m   = q[0];
    foreach (q[i]) if (q[i] < m) begin m = q[i]; idx = i; end
    q.delete(idx);
  endfunction

  task automatic set_status();
    pq_empty = (q.size() == 0);
    pq_full  = force_full || (q.size() >= CAP);
    pq_kout  = qmin();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; op = '0; key_in = '0; pq_busy = 1'b0;
    force_full = 1'b0; q.delete(); set_status(); last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic busy_at(input vec_t v, input int k);
    if (v.rej) return 1'b0;
    return (k >= 1 && k <= v.bpre) || (k >= v.bpre + 2 && k <= v.bpre + 1 + v.bpost);
  endfunction

  task automatic run_vec(input vec_t v);
    int ack_c, stb_c;
    logic [3:0] ackv;
    logic nk, upd;
    logic [15:0] rd, kin_s, exp_rd;
    logic [7:0] rc;
    logic [1:0] kind, g;
    @(posedge clk); #1;
    req[v.id] = 1'b1; op[v.id] = v.op; key_in[v.id*KW +: KW] = v.key;
    force_full = v.full; pq_busy = 1'b0; set_status();
    ack_c = -1; stb_c = -1; upd = 1'b0;
    ackv = '0; nk = 1'b0; rd = '0; kin_s = '0; rc = '0; kind = '0; g = '0;
    for (int c = 0; c < 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (pq_enq | pq_deq) begin stb_c = c; kind = {pq_enq, pq_deq}; kin_s = pq_kin; upd = 1'b1; end
      if (ack != 0) begin ack_c = c; ackv = ack; nk = nack; rd = rdata; rc = rej_cnt; g = gnt_id; end
      @(posedge clk); #1;
      if (upd) begin
        if (v.op) qremove_min(); else q.push_back(v.key);
        upd = 1'b0;
      end
      pq_busy = busy_at(v, c + 1);
      if (ack_c >= 0) req[v.id] = 1'b0;
    end
    force_full = 1'b0; pq_busy = 1'b0; req[v.id] = 1'b0; set_status();
    chk("ack_latency", 32'(ack_c), 32'(v.lat));
    chk("strobe_cycle", 32'(stb_c), v.rej ? 32'hFFFF_FFFF : 32'(1 + v.bpre));
    if (!v.rej && stb_c >= 0) begin
      chk("strobe_kind", 32'(kind), v.op ? 32'h1 : 32'h2);
      if (!v.op) chk("pq_kin", 32'(kin_s), 32'(v.key));
    end
    if (ack_c >= 0) begin
      exp_rd = (v.op && !v.rej) ? v.rd : last_rd;
      last_rd = exp_rd;
      chk("ack_vec", 32'(ackv), 32'(1) << v.id);
      chk("nack", 32'(nk), 32'(v.rej));
      chk("gnt_id", 32'(g), 32'(v.id));
      chk("rej_cnt", 32'(rc), 32'(v.rc));
      chk("rdata", 32'(rd), 32'(exp_rd));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    int n, ack_c, ptr_m, rej_m, g_id, g_c, phase, s_c, exp_ack_c, idx;
    logic outst, g_op, g_rej, just_acked, exp_stb, upd_enq, upd_deq;
    logic [15:0] g_key, exp_rd, upd_key;
    logic [3:0] pend, exp_ackv;

    //          id op key     bpre bpost full rej lat rd       rc
    vt[0] = '{2, 0, 16'h00A5, 0, 0, 0, 0, 3,  16'h0000, 0};
    vt[1] = '{1, 0, 16'h0010, 5, 3, 0, 0, 11, 16'h0000, 0};
    vt[2] = '{1, 0, 16'h0003, 0, 0, 0, 0, 3,  16'h0000, 0};
    vt[3] = '{1, 1, 16'h0000, 0, 0, 0, 0, 3,  16'h0003, 0};
    vt[4] = '{1, 1, 16'h0000, 0, 2, 0, 0, 5,  16'h0010, 0};
    vt[5] = '{3, 1, 16'h0000, 1, 0, 0, 0, 4,  16'h00A5, 0};
    vt[6] = '{1, 1, 16'h0000, 0, 0, 0, 1, 2,  16'h0000, 1};
    vt[7] = '{0, 0, 16'h1234, 0, 0, 1, 1, 2,  16'h0000, 2};
    vt[8] = '{0, 0, 16'h0777, 2, 1, 0, 0, 6,  16'h0000, 2};

    rst = 1'b0; force_full = 1'b0;
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_nack", 32'(nack), 0);
    chk("rst_strobes", 32'({pq_enq, pq_deq}), 0);
    chk("rst_rej_cnt", 32'(rej_cnt), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_pq_kin", 32'(pq_kin), 0);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Saturation: continuous dequeues against an empty queue.
    q.delete(); set_status();
    @(posedge clk); #1;
    req[0] = 1'b1; op[0] = 1'b1;
    repeat (905) @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rej_cnt_sat", 32'(rej_cnt), 32'd255);

    // Asynchronous reset while the arbiter sits in WAIT.
    @(posedge clk); #1;
    req[2] = 1'b1; op[2] = 1'b0; key_in[2*KW +: KW] = 16'h0055; pq_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 pq_busy = 1'b1; req[2] = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_ack", 32'(ack), 0);
    chk("arst_nack", 32'(nack), 0);
    chk("arst_strobes", 32'({pq_enq, pq_deq}), 0);
    chk("arst_pq_kin", 32'(pq_kin), 0);
    chk("arst_gnt_id", 32'(gnt_id), 0);
    chk("arst_rej_cnt", 32'(rej_cnt), 0);
    chk("arst_rdata", 32'(rdata), 0);
    req = '0; q.delete(); pq_busy = 1'b0; set_status();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    req = 4'b1001; op = '0;
    ack_c = -1;
    for (int c = 0; c < 20 && ack_c < 0; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        ack_c = c;
        chk("post_rst_ack", 32'(ack), 32'h1);
      end
      @(posedge clk); #1;
      if (pq_enq) ;
    end
    req = '0;
    chk("post_rst_latency", 32'(ack_c), 32'd3);

    // All requesters continuously asking: strict rotation from 0.
    do_reset();
    req = 4'hF; op = '0; key_in = {16'h4, 16'h3, 16'h2, 16'h1};
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      @(negedge clk);
      chk("rr_strobe_excl", 32'(pq_enq & pq_deq), 0);
      if (ack != 0) begin
        chk("rr_order", 32'(ack), 32'(1) << (n % 4));
        n++;
      end
      upd_enq = pq_enq; upd_key = pq_kin;
      @(posedge clk); #1;
      if (upd_enq) q.push_back(upd_key);
      set_status();
    end
    req = '0;
    chk("rr_count", 32'(n), 32'd8);

    // Randomized traffic against the transaction model.
    do_reset();
    pend = '0; ptr_m = 0; rej_m = 0; outst = 1'b0;
    g_id = 0; g_c = 0; phase = 0; s_c = 0; exp_ack_c = 0;
    g_op = 1'b0; g_rej = 1'b0; g_key = '0; exp_rd = '0; upd_key = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("strobe_excl", 32'(pq_enq & pq_deq), 0);
      just_acked = 1'b0; upd_enq = 1'b0; upd_deq = 1'b0;
      if (outst) begin
        exp_stb = !g_rej && phase == 1 && !pq_busy;
        chk("rnd_strobe", 32'(pq_enq | pq_deq), 32'(exp_stb));
        if (exp_stb && (pq_enq | pq_deq)) begin
          chk("rnd_strobe_kind", 32'({pq_enq, pq_deq}), g_op ? 32'h1 : 32'h2);
          if (!g_op) begin
            chk("rnd_pq_kin", 32'(pq_kin), 32'(g_key));
            upd_enq = 1'b1; upd_key = g_key;
          end else begin
            exp_rd = qmin(); upd_deq = 1'b1;
          end
          phase = 2; s_c = c;
        end else if (phase == 2 && !pq_busy) begin
          phase = 3; exp_ack_c = c + 1;
        end
        exp_ackv = ((g_rej && c == g_c + 2) || (phase == 3 && c == exp_ack_c))
                   ? 4'(1 << g_id) : 4'h0;
        chk("rnd_ack", 32'(ack), 32'(exp_ackv));
        if (exp_ackv != 0) begin
          chk("rnd_nack", 32'(nack), 32'(g_rej));
          if (!g_rej && g_op) last_rd = exp_rd;
          chk("rnd_rdata", 32'(rdata), 32'(last_rd));
          chk("rnd_rej_cnt", 32'(rej_cnt), 32'(rej_m));
          chk("rnd_gnt_id", 32'(gnt_id), 32'(g_id));
          outst = 1'b0; just_acked = 1'b1; pend[g_id] = 1'b0;
        end else if (c - g_c > 200) begin
          chk("rnd_service_timeout", 32'(c - g_c), 32'd200);
          break;
        end
      end else begin
        chk("rnd_ack_idle", 32'(ack), 0);
      end
      if (!outst && !just_acked && req != 0) begin
        idx = -1;
        for (int k = 0; k < NREQ; k++)
          if (idx < 0 && req[(ptr_m + k) % NREQ]) idx = (ptr_m + k) % NREQ;
        g_id = idx; g_op = op[idx]; g_key = key_in[idx*KW +: KW]; g_c = c;
        g_rej = g_op ? (q.size() == 0) : (q.size() >= CAP);
        if (g_rej && rej_m < 255) rej_m++;
        phase = 1; outst = 1'b1; ptr_m = (idx + 1) % NREQ;
      end
      @(posedge clk); #1;
      if (upd_enq) q.push_back(upd_key);
      if (upd_deq) qremove_min();
      set_status();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          op[i] = 1'($urandom % 2);
          key_in[i*KW +: KW] = 16'($urandom);
        end
      end
      req = pend;
      pq_busy = ($urandom % 3 == 0);
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
